// File: rtl/axi4_lite_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | axi4_lite_pkg: response codes and FSM states for the register slave |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package axi4_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [0:0] {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } wstate_t;

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rstate_t;

endpackage
`default_nettype wire

// File: rtl/axi4_lite_strb_merge.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | axi4_lite_strb_merge: per-byte select between old and new data     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module axi4_lite_strb_merge #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0]   old_data,
  input  logic [DATA_WIDTH-1:0]   new_data,
  input  logic [DATA_WIDTH/8-1:0] strb,
  output logic [DATA_WIDTH-1:0]   merged
);

  for (genvar b = 0; b < DATA_WIDTH/8; b++) begin : g_byte
    assign merged[b*8 +: 8] = strb[b] ? new_data[b*8 +: 8] : old_data[b*8 +: 8];
  end

endmodule
`default_nettype wire

// File: rtl/axi4_lite_s_regs.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | axi4_lite_s_regs: AXI4-Lite slave exposing a flat register file    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module axi4_lite_s_regs
  import axi4_lite_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_REGS   = 16
) (
  input  logic                           ACLK,
  input  logic                           ARESETn,
  input  logic [ADDR_WIDTH-1:0]          AWADDR,
  input  logic [2:0]                     AWPROT,
  input  logic                           AWVALID,
  output logic                           AWREADY,
  input  logic [DATA_WIDTH-1:0]          WDATA,
  input  logic [DATA_WIDTH/8-1:0]        WSTRB,
  input  logic                           WVALID,
  output logic                           WREADY,
  output logic [1:0]                     BRESP,
  output logic                           BVALID,
  input  logic                           BREADY,
  input  logic [ADDR_WIDTH-1:0]          ARADDR,
  input  logic [2:0]                     ARPROT,
  input  logic                           ARVALID,
  output logic                           ARREADY,
  output logic [DATA_WIDTH-1:0]          RDATA,
  output logic [1:0]                     RRESP,
  output logic                           RVALID,
  input  logic                           RREADY,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
  output logic [NUM_REGS-1:0]            wr_pulse_o
);

  localparam int c_BYTE_LSB = $clog2(DATA_WIDTH/8);

  if (!(DATA_WIDTH == 32 || DATA_WIDTH == 64)) begin : g_bad_data_width
    $error("axi4_lite_s_regs: DATA_WIDTH must be 32 or 64");
  end
  if (NUM_REGS > (1 << (ADDR_WIDTH - c_BYTE_LSB))) begin : g_bad_num_regs
    $error("axi4_lite_s_regs: NUM_REGS exceeds the addressable register space");
  end

  wstate_t r_wstate, w_wstate_nxt;
  rstate_t r_rstate, w_rstate_nxt;
  logic    r_live;

  logic                           r_aw_held, r_w_held;
  logic [ADDR_WIDTH-1:0]          r_awaddr;
  logic [DATA_WIDTH-1:0]          r_wdata;
  logic [DATA_WIDTH/8-1:0]        r_wstrb;
  logic                           r_bvalid, r_rvalid;
  logic [1:0]                     r_bresp, r_rresp;
  logic [DATA_WIDTH-1:0]          r_rdata;
  logic [NUM_REGS*DATA_WIDTH-1:0] r_regs;
  logic [NUM_REGS-1:0]            r_wr_pulse;

  logic                    w_aw_hs, w_w_hs, w_ar_hs, w_commit;
  logic [ADDR_WIDTH-1:0]   w_awaddr;
  logic [DATA_WIDTH-1:0]   w_wdata, w_wold, w_merged, w_rd_data;
  logic [DATA_WIDTH/8-1:0] w_wstrb;
  logic [31:0]             w_awidx, w_aridx;
  logic                    w_aw_ok, w_ar_ok;
  logic [NUM_REGS-1:0]     w_wsel;
  logic                    w_unused;

  // READY stays low until the first edge after reset release
  assign AWREADY = r_live && (r_wstate == W_IDLE) && !r_aw_held;
  assign WREADY  = r_live && (r_wstate == W_IDLE) && !r_w_held;
  assign ARREADY = r_live && (r_rstate == R_IDLE);

  assign w_aw_hs = AWVALID && AWREADY;
  assign w_w_hs  = WVALID && WREADY;
  assign w_ar_hs = ARVALID && ARREADY;

  assign w_awaddr = r_aw_held ? r_awaddr : AWADDR;
  assign w_wdata  = r_w_held ? r_wdata : WDATA;
  assign w_wstrb  = r_w_held ? r_wstrb : WSTRB;
  assign w_commit = (r_wstate == W_IDLE) && (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);

  assign w_awidx = 32'(w_awaddr[ADDR_WIDTH-1:c_BYTE_LSB]);
  assign w_aridx = 32'(ARADDR[ADDR_WIDTH-1:c_BYTE_LSB]);
  assign w_aw_ok = w_awidx < 32'(NUM_REGS);
  assign w_ar_ok = w_aridx < 32'(NUM_REGS);

  assign w_unused = ^{AWPROT, ARPROT, w_awaddr[c_BYTE_LSB-1:0], ARADDR[c_BYTE_LSB-1:0]};

  always_comb begin
    w_wold    = '0;
    w_rd_data = '0;
    w_wsel    = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_awidx == 32'(i)) begin
        w_wold    = r_regs[i*DATA_WIDTH +: DATA_WIDTH];
        w_wsel[i] = w_commit;
      end
      if (w_aridx == 32'(i)) begin
        w_rd_data = r_regs[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  axi4_lite_strb_merge #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_strb_merge (
    .old_data (w_wold),
    .new_data (w_wdata),
    .strb     (w_wstrb),
    .merged   (w_merged)
  );

  always_comb begin
    w_wstate_nxt = r_wstate;
    w_rstate_nxt = r_rstate;
    case (r_wstate)
      W_IDLE:  if (w_commit) w_wstate_nxt = W_RESP;
      W_RESP:  if (r_bvalid && BREADY) w_wstate_nxt = W_IDLE;
      default: w_wstate_nxt = W_IDLE;
    endcase
    case (r_rstate)
      R_IDLE:  if (w_ar_hs) w_rstate_nxt = R_DATA;
      R_DATA:  if (r_rvalid && RREADY) w_rstate_nxt = R_IDLE;
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_wstate <= W_IDLE;
      r_rstate <= R_IDLE;
      r_live   <= 1'b0;
    end else begin
      r_wstate <= w_wstate_nxt;
      r_rstate <= w_rstate_nxt;
      r_live   <= 1'b1;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_aw_held  <= 1'b0;
      r_w_held   <= 1'b0;
      r_awaddr   <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_bvalid   <= 1'b0;
      r_bresp    <= RESP_OKAY;
      r_rvalid   <= 1'b0;
      r_rresp    <= RESP_OKAY;
      r_rdata    <= '0;
      r_regs     <= '0;
      r_wr_pulse <= '0;
    end else begin
      r_wr_pulse <= w_wsel;
      if (w_commit) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
        r_bvalid  <= 1'b1;
        r_bresp   <= w_aw_ok ? RESP_OKAY : RESP_SLVERR;
        for (int i = 0; i < NUM_REGS; i++) begin
          if (w_wsel[i]) r_regs[i*DATA_WIDTH +: DATA_WIDTH] <= w_merged;
        end
      end else begin
        if (w_aw_hs) begin
          r_aw_held <= 1'b1;
          r_awaddr  <= AWADDR;
        end
        if (w_w_hs) begin
          r_w_held <= 1'b1;
          r_wdata  <= WDATA;
          r_wstrb  <= WSTRB;
        end
      end
      if (r_bvalid && BREADY) r_bvalid <= 1'b0;

      // Sampled at the handshake edge, so a same-edge commit is not visible
      if (w_ar_hs) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rd_data;
        r_rresp  <= w_ar_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (r_rvalid && RREADY) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  assign BVALID     = r_bvalid;
  assign BRESP      = r_bresp;
  assign RVALID     = r_rvalid;
  assign RRESP      = r_rresp;
  assign RDATA      = r_rdata;
  assign regs_o     = r_regs;
  assign wr_pulse_o = r_wr_pulse;

endmodule
`default_nettype wire

// File: doc/axi4_lite_s_regs.md
AXI4_LITE_S_REGS -- requirements
Module: axi4_lite_s_regs

Interface
REQ-001 SHALL have parameter DATA_WIDTH, 32, data bus width (32 or 64 only).
REQ-002 SHALL have parameter ADDR_WIDTH, 8, byte address width.
REQ-003 SHALL have parameter NUM_REGS, 16, number of DATA_WIDTH-wide registers.
REQ-004 SHALL have ports, one per line:
- ACLK input 1: single clock; all logic on its rising edge.
- ARESETn input 1: asynchronous, active-low reset.
- AWADDR input ADDR_WIDTH, AWPROT input 3 (ignored), AWVALID input 1, AWREADY output 1.
- WDATA input DATA_WIDTH, WSTRB input DATA_WIDTH/8, WVALID input 1, WREADY output 1.
- BRESP output 2, BVALID output 1, BREADY input 1.
- ARADDR input ADDR_WIDTH, ARPROT input 3 (ignored), ARVALID input 1, ARREADY output 1.
- RDATA output DATA_WIDTH, RRESP output 2, RVALID output 1, RREADY input 1.
- regs_o output NUM_REGS*DATA_WIDTH: flat register contents, reg i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- wr_pulse_o output NUM_REGS: one-cycle pulse per register on a committed write.

Function
REQ-005 SHALL accept AW and W independently, in any order or in the same cycle; each channel gets one beat per write transaction.
REQ-006 Write FSM SHALL have states W_IDLE, W_RESP; AWREADY=1 in W_IDLE until AW captured; WREADY=1 in W_IDLE until W captured; both 0 in W_RESP.
REQ-007 SHALL commit the write and assert BVALID on the clock edge after both beats are held (same-cycle AW+W -> BVALID next cycle); FSM -> W_RESP.
REQ-008 SHALL hold BVALID and BRESP stable until BVALID&&BREADY, then return to W_IDLE with AWREADY=WREADY=1 the following cycle.
REQ-009 Register index SHALL be addr[ADDR_WIDTH-1:log2(DATA_WIDTH/8)]; low byte-offset bits ignored.
REQ-010 Write SHALL update only bytes with WSTRB bit set; WSTRB=0 -> OKAY, no change, but wr_pulse_o still pulses.
REQ-011 Index >= NUM_REGS SHALL return SLVERR (2'b10), discard the write, no wr_pulse_o; in range returns OKAY (2'b00).
REQ-012 Read FSM SHALL have states R_IDLE, R_DATA; ARREADY=1 only in R_IDLE; on AR handshake -> R_DATA with RVALID=1 next cycle.
REQ-013 RDATA SHALL be register contents sampled at the AR handshake edge; same-edge write commit to that register -> old value.
REQ-014 Out-of-range read SHALL return RDATA=0, RRESP=SLVERR.
REQ-015 SHALL hold RVALID/RDATA/RRESP stable until RREADY; return to R_IDLE on handshake.
REQ-016 Read and write paths SHALL operate concurrently and independently; one outstanding transaction per direction.
REQ-017 SHALL never wait on a VALID before asserting the matching READY beyond REQ-006/REQ-012.
REQ-018 Illegal DATA_WIDTH or NUM_REGS > 2^(ADDR_WIDTH-log2(DATA_WIDTH/8)) SHALL abort elaboration with an error.

Reset
REQ-019 ARESETn low SHALL asynchronously clear all registers, BVALID, RVALID, wr_pulse_o, RDATA, BRESP, RRESP to 0, and force both FSMs to idle.
REQ-020 AWREADY/WREADY/ARREADY SHALL be 0 while ARESETn is low and 1 on the first edge after release.
REQ-021 Reset mid-transaction SHALL drop it without response; no partial register update.

Structure
REQ-022 Shared package axi4_lite_pkg SHALL hold RESP_OKAY, RESP_SLVERR, and write/read FSM state encodings.
REQ-023 Byte-strobe merge SHALL be sub-module axi4_lite_strb_merge (old data, new data, strobe -> merged); all else in one module.

Verification
REQ-024 AW+W same cycle, addr 0x04, data 0xDEADBEEF, strb 0xF -> BVALID next cycle, BRESP=0, reg1=0xDEADBEEF, wr_pulse_o[1] one cycle.
REQ-025 W three cycles before AW, addr 0x08, strb 0x3, data 0x12345678 over 0xFFFFFFFF -> reg2=0xFFFF5678, single BVALID.
REQ-026 Read addr 0x40 with NUM_REGS=16 -> RRESP=2'b10, RDATA=0; write there -> BRESP=2'b10, regs unchanged.
REQ-027 BREADY/RREADY held low 5 cycles -> BVALID/RVALID and payload stable, AWREADY/ARREADY stay 0, then one handshake each.
REQ-028 ARESETn pulled low between AW capture and W -> all VALIDs 0, regs 0, no BVALID after release; subsequent write works normally.
REQ-029 Concurrent read and write to reg 3 (old 0x0, new 0xA5A5A5A5) on same edge -> RDATA=0x0; next read -> 0xA5A5A5A5.
